// File: rtl/wb_line_responder.sv
// Wishbone slave that serves 128-bit lines from an internal array after a fixed
// LATENCY, with byte-masked writes, abort on dropped strobe, and flop-only outputs.
module wb_line_responder #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         CYC,
    input  logic         STB,
    input  logic         WE,
    input  logic [11:0]  ADR,
    input  logic [15:0]  SEL,
    input  logic [127:0] DAT_M,
    output logic [127:0] DAT_S,
    output logic         ACK
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] LAT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [3:0]          lat_cnt_q;
    logic [ADDR_W-1:0]   adr_q;
    logic                we_q;
    logic [127:0]        dat_s_q;
    logic                ack_q;
    logic [127:0]        mem_q [DEPTH];
    logic                req;
    logic                wr_en;

    assign req   = CYC & STB;
    assign wr_en = (state_q == RESP) && we_q && req;
    assign ACK   = ack_q;
    assign DAT_S = dat_s_q;

    // Upper address bits alias onto the same lines.
    generate
        if (ADDR_W < 12) begin : g_alias
            logic unused_adr_hi;
            assign unused_adr_hi = ^ADR[11:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            dat_s_q   <= '0;
            ack_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q   <= 1'b0;
                    dat_s_q <= '0;
                    if (req) begin
                        adr_q <= ADR[ADDR_W-1:0];
                        we_q  <= WE;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            dat_s_q <= WE ? '0 : mem_q[ADR[ADDR_W-1:0]];
                        end else begin
                            state_q   <= WAIT;
                            lat_cnt_q <= LAT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end else if (lat_cnt_q == 4'd0) begin
                        // Sample the line one cycle ahead of ACK so the output stays a pure flop.
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        dat_s_q <= we_q ? '0 : mem_q[adr_q];
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    dat_s_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    dat_s_q <= '0;
                end
            endcase
        end
    end

    // Writes commit at the end of the ACK cycle; reset forces IDLE, which blocks them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 16; i++) begin
                if (SEL[i]) begin
                    mem_q[adr_q][8*i +: 8] <= DAT_M[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_line_responder.sv
// Directed bench for wb_line_responder (LATENCY = 2, ADDR_W = 8): reset, full and
// partial writes, aborts, aliasing, back-to-back streaming and reset mid-request.
module tb_wb_line_responder;

    logic         clk;
    logic         rst_n;
    logic         CYC;
    logic         STB;
    logic         WE;
    logic [11:0]  ADR;
    logic [15:0]  SEL;
    logic [127:0] DAT_M;
    logic [127:0] DAT_S;
    logic         ACK;

    int           assertCount = 0;
    int           failCount   = 0;
    int           ackCount;
    int           streamIdx;
    logic [127:0] rdata;
    logic [127:0] exp10;

    localparam logic [127:0] FULL_DATA = 128'h0123456789ABCDEF_FEDCBA9876543210;

    wb_line_responder #(.LATENCY(2), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .CYC   (CYC),
        .STB   (STB),
        .WE    (WE),
        .ADR   (ADR),
        .SEL   (SEL),
        .DAT_M (DAT_M),
        .DAT_S (DAT_S),
        .ACK   (ACK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [11:0] adr, input logic [15:0] sel, input logic [127:0] dat);
        CYC   = cyc;
        STB   = stb;
        WE    = we;
        ADR   = adr;
        SEL   = sel;
        DAT_M = dat;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lineData(input int i);
        return {32'hC0DE0000 | 32'(i), 32'h11111111 * 32'(i + 1), 32'hFACE0000 | 32'(i), 32'(i)};
    endfunction

    // Full handshake: request held until the cycle after ACK, latency and idle data checked.
    task automatic runTransfer(input string tag, input logic we, input logic [11:0] adr,
                               input logic [15:0] sel, input logic [127:0] dat, output logic [127:0] rd);
        int  lat;
        bit  got;
        lat = 0;
        got = 0;
        rd  = '0;
        applyStimulus(1'b1, 1'b1, we, adr, sel, dat);
        while (!got && lat < 20) begin
            nextCycle();
            lat++;
            if (ACK === 1'b1) begin
                got = 1;
                rd  = DAT_S;
            end else begin
                checkOutput({tag, "_dataBeforeAck"}, DAT_S, 128'h0);
            end
        end
        checkOutput({tag, "_latency"}, 128'(lat), 128'd2);
        if (we) checkOutput({tag, "_writeAckData"}, rd, 128'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 128'h0);
        checkOutput({tag, "_ackOneCycle"}, 128'(ACK), 128'd0);
        checkOutput({tag, "_dataAfterAck"}, DAT_S, 128'h0);
    endtask

    task automatic countAcks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            nextCycle();
            if (ACK !== 1'b0) n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 128'h0);
        nextCycle();
        nextCycle();
        checkOutput("resetAck", 128'(ACK), 128'd0);
        checkOutput("resetData", DAT_S, 128'h0);
        rst_n = 1'b1;
        nextCycle();

        runTransfer("read005", 1'b0, 12'h005, 16'h0, 128'h0, rdata);

        runTransfer("wrFull010", 1'b1, 12'h010, 16'hFFFF, FULL_DATA, rdata);
        exp10 = FULL_DATA;
        runTransfer("rdFull010", 1'b0, 12'h010, 16'h0, 128'h0, rdata);
        checkOutput("rdFull010_value", rdata, exp10);

        runTransfer("wrPart010", 1'b1, 12'h010, 16'h0003, {112'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'hBEEF}, rdata);
        exp10 = 128'h0123456789ABCDEF_FEDCBA987654BEEF;
        runTransfer("rdPart010", 1'b0, 12'h010, 16'h0, 128'h0, rdata);
        checkOutput("rdPart010_value", rdata, exp10);

        runTransfer("wrSel0", 1'b1, 12'h010, 16'h0000, 128'h5555_5555_5555_5555_5555_5555_5555_5555, rdata);
        runTransfer("rdSel0", 1'b0, 12'h010, 16'h0, 128'h0, rdata);
        checkOutput("rdSel0_value", rdata, exp10);

        runTransfer("rdAlias110", 1'b0, 12'h110, 16'h0, 128'h0, rdata);
        checkOutput("rdAlias110_value", rdata, exp10);

        applyStimulus(1'b1, 1'b1, 1'b0, 12'h010, 16'h0, 128'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 16'h0, 128'h0);
        countAcks(5, ackCount);
        checkOutput("abortRead_noAck", 128'(ackCount), 128'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 128'h0);

        applyStimulus(1'b1, 1'b1, 1'b1, 12'h010, 16'hFFFF, 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h010, 16'hFFFF, 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD);
        countAcks(5, ackCount);
        checkOutput("abortWrite_noAck", 128'(ackCount), 128'd0);
        runTransfer("rdAfterAbortWr", 1'b0, 12'h010, 16'h0, 128'h0, rdata);
        checkOutput("rdAfterAbortWr_value", rdata, exp10);

        // Strobe dropped in the ACK cycle itself: ACK is already committed but the write is not.
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h010, 16'hFFFF, 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0);
        nextCycle();
        nextCycle();
        checkOutput("dropInResp_ack", 128'(ACK), 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 128'h0);
        nextCycle();
        runTransfer("rdAfterDropResp", 1'b0, 12'h010, 16'h0, 128'h0, rdata);
        checkOutput("rdAfterDropResp_value", rdata, exp10);

        for (int i = 0; i < 8; i++) begin
            runTransfer($sformatf("preload%0d", i), 1'b1, 12'(i), 16'hFFFF, lineData(i), rdata);
        end

        ackCount  = 0;
        streamIdx = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000, 16'h0, 128'h0);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            nextCycle();
            if (ACK === 1'b1) begin
                checkOutput($sformatf("stream%0d_data", streamIdx), DAT_S, lineData(streamIdx));
                checkOutput($sformatf("stream%0d_cycle", streamIdx), 128'(cyc), 128'(3 * streamIdx + 2));
                ackCount++;
                streamIdx++;
                ADR = 12'(streamIdx);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 128'h0);
        checkOutput("stream_ackCount", 128'(ackCount), 128'd8);
        nextCycle();
        nextCycle();

        applyStimulus(1'b1, 1'b1, 1'b0, 12'h005, 16'h0, 128'h0);
        nextCycle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstInWait_ack", 128'(ACK), 128'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 128'h0);
        nextCycle();
        rst_n = 1'b1;
        countAcks(4, ackCount);
        checkOutput("rstInWait_noAck", 128'(ackCount), 128'd0);
        runTransfer("rdAfterRstWait", 1'b0, 12'h010, 16'h0, 128'h0, rdata);
        checkOutput("rdAfterRstWait_value", rdata, exp10);

        applyStimulus(1'b1, 1'b1, 1'b1, 12'h010, 16'hFFFF, 128'h7777_7777_7777_7777_7777_7777_7777_7777);
        nextCycle();
        nextCycle();
        checkOutput("rstInResp_ackBefore", 128'(ACK), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstInResp_ackDrop", 128'(ACK), 128'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 128'h0);
        rst_n = 1'b1;
        nextCycle();
        runTransfer("rdAfterRstResp", 1'b0, 12'h010, 16'h0, 128'h0, rdata);
        checkOutput("rdAfterRstResp_value", rdata, exp10);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
